// File: rtl/imm_gen_pkg.sv
// Shared types for the decode->execute immediate generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional feature macro: IMM_GEN_BRANCH_JUMP_EN.
package imm_gen_pkg;

  localparam int IMM_W   = 16;
  localparam int FIELD_W = 26;

  // Extension opcodes; 5..7 are undefined and flagged illegal.
  typedef enum logic [2:0] {
    EXT_ZERO   = 3'd0,
    EXT_LUI    = 3'd1,
    EXT_SIGN   = 3'd2,
    EXT_BRANCH = 3'd3,
    EXT_JUMP   = 3'd4
  } ext_op_e;

  // Buffer occupancy: main only drives outputs, skid catches the entry
  // that arrives while main is stalled.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extension (field, op, pc4 -> imm, illegal).
// Latency: 0 cycles.
// Backpressure: none; IMM_GEN_BRANCH_JUMP_EN enables branch/jump modes.
module imm_ext_core
  import imm_gen_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [FIELD_W-1:0] field,
  input  logic [2:0]         op,
  input  logic [DATA_W-1:0]  pc4,
  output logic [DATA_W-1:0]  imm,
  output logic               illegal
);

  logic [IMM_W-1:0] imm16;
  assign imm16 = field[IMM_W-1:0];

`ifdef IMM_GEN_BRANCH_JUMP_EN
  // Low PC bits are replaced by the jump field, so they never reach logic.
  logic unused_pc_lo;
  assign unused_pc_lo = ^pc4[27:0];
`else
  // Without branch/jump support the PC and the upper field bits are dead.
  logic unused_pc_field;
  assign unused_pc_field = ^{pc4, field[FIELD_W-1:IMM_W]};
`endif

  // Select the extension; undefined or compiled-out opcodes give 0 + illegal.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (ext_op_e'(op))
      EXT_ZERO: imm = DATA_W'(imm16);
      EXT_LUI:  imm = DATA_W'($signed({imm16, 16'h0000}));
      EXT_SIGN: imm = DATA_W'($signed(imm16));
`ifdef IMM_GEN_BRANCH_JUMP_EN
      EXT_BRANCH: imm = DATA_W'($signed({imm16, 2'b00}));
      EXT_JUMP:   imm = {pc4[DATA_W-1:28], field, 2'b00};
`endif
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry (main + skid) buffer.
// Latency: 1 cycle from accept to out_valid when main is empty or popping.
// Backpressure: in_ready = skid empty, registered; flush drops everything.
// Optional feature macro: IMM_GEN_BRANCH_JUMP_EN (branch offset / jump target).
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FIELD_W-1:0] in_field,
  input  logic [2:0]         in_op,
  input  logic [DATA_W-1:0]  in_pc4,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_imm,
  output logic               out_illegal,
  output logic [TAG_W-1:0]   out_tag
);

  // Stored entry: the extension result, never the raw field.
  typedef struct packed {
    logic [DATA_W-1:0] imm;
    logic              illegal;
    logic [TAG_W-1:0]  tag;
  } imm_entry_t;

  occ_e       state_q;
  occ_e       state_nxt;
  imm_entry_t main_q;
  imm_entry_t skid_q;
  imm_entry_t new_entry;
  logic       accept;
  logic       pop;

  imm_ext_core #(
    .DATA_W (DATA_W)
  ) u_ext (
    .field   (in_field),
    .op      (in_op),
    .pc4     (in_pc4),
    .imm     (new_entry.imm),
    .illegal (new_entry.illegal)
  );
  assign new_entry.tag = in_tag;

  // A flushed cycle never accepts; a pop during flush is still seen downstream.
  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OCC_EMPTY;
    else        state_q <= state_nxt;
  end

  // Occupancy follows accept/pop; flush empties the buffer outright.
  always_comb begin
    state_nxt = state_q;
    if (flush) begin
      state_nxt = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (accept) state_nxt = OCC_ONE;
        OCC_ONE: begin
          if (accept && !pop)      state_nxt = OCC_FULL;
          else if (!accept && pop) state_nxt = OCC_EMPTY;
        end
        OCC_FULL:  if (pop) state_nxt = OCC_ONE;
        default:   state_nxt = OCC_EMPTY;
      endcase
    end
  end

  // Handshake outputs decode from state only, so in_ready ignores out_ready.
  always_comb begin
    out_valid = (state_q != OCC_EMPTY);
    in_ready  = (state_q != OCC_FULL);
  end

  // Entry storage: new entries land in main unless main is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      if (state_q == OCC_FULL) begin
        if (pop) main_q <= skid_q;
      end else if (accept) begin
        if (state_q == OCC_EMPTY || pop) main_q <= new_entry;
        else                             skid_q <= new_entry;
      end
    end
  end

  assign out_imm     = main_q.imm;
  assign out_illegal = main_q.illegal;
  assign out_tag     = main_q.tag;

endmodule
